oclib_csr_fanout: RTL

Single-clock CSR fan-out with per-transaction timeout. Accepts one upstream level-protocol CSR request, steers it to one of `Channels` downstream CSR targets selected by a one-hot select, and returns the target's ready/error/rdata upstream as a one-cycle pulse. Unresponsive targets and illegal selects are converted into error responses, so a hung or missing target never stalls the upstream CSR master. Sits between a CSR master (or a CSR clock-domain synchronizer output) and a set of same-clock CSR targets.

---
 rtl/oclib_csr_fanout_if.sv | 46 ++++
 rtl/oclib_csr_fanout.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/oclib_csr_fanout_if.sv
// CSR fan-out bus: one upstream CSR port plus Channels downstream CSR ports.
//
// Handshake (level protocol, both directions): a requester raises read or
// write together with address/wdata and holds them until the responder pulses
// ready and/or error for exactly one cycle, carrying rdata in that same cycle.
// The requester then drops read/write. Feedback outside an outstanding request
// carries no meaning.
interface oclib_csr_fanout_if #(
  parameter int Channels = 4
);
  // upstream request
  logic [Channels-1:0]       csrSelectIn;
  logic [31:0]               csrInAddress;
  logic [31:0]               csrInWdata;
  logic                      csrInRead;
  logic                      csrInWrite;
  // upstream feedback
  logic [31:0]               csrInFbRdata;
  logic                      csrInFbReady;
  logic                      csrInFbError;
  // downstream requests
  logic [Channels-1:0][31:0] csrOutAddress;
  logic [Channels-1:0][31:0] csrOutWdata;
  logic [Channels-1:0]       csrOutRead;
  logic [Channels-1:0]       csrOutWrite;
  // downstream feedback
  logic [Channels-1:0][31:0] csrOutFbRdata;
  logic [Channels-1:0]       csrOutFbReady;
  logic [Channels-1:0]       csrOutFbError;

  // view of the CSR master that owns the upstream request and the targets' feedback
  modport master (
    output csrSelectIn, csrInAddress, csrInWdata, csrInRead, csrInWrite,
    input  csrInFbRdata, csrInFbReady, csrInFbError,
    input  csrOutAddress, csrOutWdata, csrOutRead, csrOutWrite,
    output csrOutFbRdata, csrOutFbReady, csrOutFbError
  );

  // view of the fan-out block
  modport slave (
    input  csrSelectIn, csrInAddress, csrInWdata, csrInRead, csrInWrite,
    output csrInFbRdata, csrInFbReady, csrInFbError,
    output csrOutAddress, csrOutWdata, csrOutRead, csrOutWrite,
    input  csrOutFbRdata, csrOutFbReady, csrOutFbError
  );
endinterface

// File: rtl/oclib_csr_fanout.sv
// CSR fan-out: steers one upstream level-protocol request to a one-hot selected
// target, returns its response as a one-cycle pulse, and converts illegal
// requests and unresponsive targets into error responses.
module oclib_csr_fanout #(
  parameter int Channels      = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clock,
  input  logic                reset,
  oclib_csr_fanout_if.slave   csr,
  output logic                timeoutPulse,
  output logic [15:0]         timeoutCount,
  output logic [1:0]          stateDebug
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StFinish = 2'd2
  } state_e;

  // counter only needs to reach TimeoutCycles-1
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Channels-1:0] sel_q, sel_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [Channels-1:0] dn_rd_q, dn_rd_d;
  logic [Channels-1:0] dn_wr_q, dn_wr_d;
  logic [31:0]         fb_rdata_q, fb_rdata_d;
  logic                fb_ready_q, fb_ready_d;
  logic                fb_error_q, fb_error_d;
  logic                tpulse_q, tpulse_d;
  logic [15:0]         tcount_q, tcount_d;

  logic                req_any;
  logic                req_legal;
  logic                expire;
  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                sel_error;

  assign req_any   = csr.csrInRead | csr.csrInWrite;
  assign req_legal = ($countones(csr.csrSelectIn) == 1) && !(csr.csrInRead && csr.csrInWrite);
  assign expire    = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

  // feedback of the captured channel only; other channels are ignored
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_error = 1'b0;
    for (int i = 0; i < Channels; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | csr.csrOutFbRdata[i];
        sel_ready = sel_ready | csr.csrOutFbReady[i];
        sel_error = sel_error | csr.csrOutFbError[i];
      end
    end
  end

  // next-state and registered-output logic; pulses default low every cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dn_rd_d    = '0;
    dn_wr_d    = '0;
    fb_rdata_d = '0;
    fb_ready_d = 1'b0;
    fb_error_d = 1'b0;
    tpulse_d   = 1'b0;
    tcount_d   = tcount_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          sel_d   = csr.csrSelectIn;
          addr_d  = csr.csrInAddress;
          wdata_d = csr.csrInWdata;
          cnt_d   = '0;
          if (req_legal) begin
            dn_rd_d = csr.csrSelectIn & {Channels{csr.csrInRead}};
            dn_wr_d = csr.csrSelectIn & {Channels{csr.csrInWrite}};
            state_d = StWait;
          end else begin
            fb_error_d = 1'b1;
            state_d    = StFinish;
          end
        end
      end
      StWait: begin
        if (sel_ready || sel_error) begin
          // a response in the expiry cycle still wins over the timeout
          fb_ready_d = sel_ready;
          fb_error_d = sel_error;
          fb_rdata_d = sel_rdata;
          state_d    = StFinish;
        end else if (expire) begin
          fb_error_d = 1'b1;
          tpulse_d   = 1'b1;
          if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
          state_d    = StFinish;
        end else begin
          dn_rd_d = dn_rd_q;
          dn_wr_d = dn_wr_q;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StFinish: begin
        // a held level request must be released before another is accepted
        if (!req_any) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // state and output registers, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dn_rd_q    <= '0;
      dn_wr_q    <= '0;
      fb_rdata_q <= '0;
      fb_ready_q <= 1'b0;
      fb_error_q <= 1'b0;
      tpulse_q   <= 1'b0;
      tcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dn_rd_q    <= dn_rd_d;
      dn_wr_q    <= dn_wr_d;
      fb_rdata_q <= fb_rdata_d;
      fb_ready_q <= fb_ready_d;
      fb_error_q <= fb_error_d;
      tpulse_q   <= tpulse_d;
      tcount_q   <= tcount_d;
    end
  end

  assign csr.csrOutAddress = {Channels{addr_q}};
  assign csr.csrOutWdata   = {Channels{wdata_q}};
  assign csr.csrOutRead    = dn_rd_q;
  assign csr.csrOutWrite   = dn_wr_q;
  assign csr.csrInFbRdata  = fb_rdata_q;
  assign csr.csrInFbReady  = fb_ready_q;
  assign csr.csrInFbError  = fb_error_q;
  assign timeoutPulse      = tpulse_q;
  assign timeoutCount      = tcount_q;
  assign stateDebug        = state_q;

endmodule
